// File: rtl/mem_arbiter.sv
// Arbitrates the shared single-port data memory between the CPU data port and the camera port.
// Optional `MEM_ARB_RANGE_CHECK_EN`: granted addresses >= LIMIT complete at once with err=1.
module mem_arbiter #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                RD_LAT   = 1,
    parameter int                MAX_WAIT = 8,
    parameter logic [ADDR_W-1:0] LIMIT    = ADDR_W'('h80000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              cam_req,
    input  logic              cam_we,
    input  logic [ADDR_W-1:0] cam_addr,
    input  logic [DATA_W-1:0] cam_wdata,
    output logic              cam_ack,
    output logic [DATA_W-1:0] cam_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t            state;
    logic   [CW-1:0]   starve;
    logic   [LW-1:0]   wcnt;
    logic              lat_we;

    logic              any_req;
    logic              cam_wins;
    logic              grant;
    logic              cam_active;
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic              oob;

    // The camera only overrides a competing CPU request once it has been denied MAX_WAIT times.
    assign any_req    = cpu_req | cam_req;
    assign cam_wins   = cam_req & (~cpu_req | (starve == CW'(MAX_WAIT)));
    assign grant      = (state == IDLE) & any_req;
    assign cam_active = (state != IDLE) & owner;
    assign g_we       = cam_wins ? cam_we    : cpu_we;
    assign g_addr     = cam_wins ? cam_addr  : cpu_addr;
    assign g_wdata    = cam_wins ? cam_wdata : cpu_wdata;

`ifdef MEM_ARB_RANGE_CHECK_EN
    assign oob = (g_addr >= LIMIT);
`else
    logic unused_limit;
    assign unused_limit = ^LIMIT;
    assign oob          = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            starve    <= '0;
            wcnt      <= '0;
            lat_we    <= 1'b0;
            owner     <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            cam_ack   <= 1'b0;
            cpu_rdata <= '0;
            cam_rdata <= '0;
        end else begin
            // NOTE: pulse outputs default low every edge so each strobe/ack lasts exactly one
            // cycle; all state here uses non-blocking assignment so every branch sees pre-edge values.
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            cam_ack   <= 1'b0;
            err       <= 1'b0;

            if (grant && cam_wins)
                starve <= '0;
            else if (cam_req && !cam_active && starve != CW'(MAX_WAIT))
                starve <= starve + 1'b1;

            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner  <= cam_wins;
                        lat_we <= g_we;
                        busy   <= 1'b1;
                        if (oob) begin
                            state <= DONE;
                            err   <= 1'b1;
                            if (cam_wins) begin
                                cam_ack   <= 1'b1;
                                cam_rdata <= '0;
                            end else begin
                                cpu_ack   <= 1'b1;
                                cpu_rdata <= '0;
                            end
                        end else begin
                            state     <= ISSUE;
                            mem_en    <= 1'b1;
                            mem_we    <= g_we;
                            mem_addr  <= g_addr;
                            mem_wdata <= g_wdata;
                        end
                    end
                end
                ISSUE: begin
                    if (lat_we) begin
                        state <= DONE;
                        if (owner) cam_ack <= 1'b1;
                        else       cpu_ack <= 1'b1;
                    end else begin
                        state <= WAIT;
                        wcnt  <= LW'(RD_LAT - 1);
                    end
                end
                WAIT: begin
                    // Read data is only valid on the last wait cycle; capture it then.
                    if (wcnt == '0) begin
                        state <= DONE;
                        if (owner) begin
                            cam_ack   <= 1'b1;
                            cam_rdata <= mem_rdata;
                        end else begin
                            cpu_ack   <= 1'b1;
                            cpu_rdata <= mem_rdata;
                        end
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a timestamp-level model predicts every grant,
// memory strobe and ack; a negedge monitor compares the DUT against the queued expectations.
module tb_mem_arbiter;

    localparam int          RD_LAT   = 2;
    localparam int          MAX_WAIT = 8;
    localparam logic [31:0] LIMIT    = 32'h80000;

    logic        clk, rst;
    logic        cpu_req, cpu_we, cam_req, cam_we;
    logic [31:0] cpu_addr, cpu_wdata, cam_addr, cam_wdata;
    logic        cpu_ack, cam_ack, mem_en, mem_we, owner, busy, err;
    logic [31:0] cpu_rdata, cam_rdata, mem_addr, mem_wdata, mem_rdata;

    mem_arbiter #(.DATA_W(32), .ADDR_W(32), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT), .LIMIT(LIMIT)) dut (
        .clk(clk), .reset(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .cam_req(cam_req), .cam_we(cam_we), .cam_addr(cam_addr), .cam_wdata(cam_wdata),
        .cam_ack(cam_ack), .cam_rdata(cam_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner), .busy(busy), .err(err)
    );

    typedef struct {
        bit          owner;
        bit          we;
        bit          oob;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          issue;
        int          ack;
    } txn_t;

    typedef struct {
        int          due;
        logic [31:0] val;
    } rd_t;

    txn_t        exp_q[$];
    rd_t         rd_q[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] phys_mem[logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    int          pe = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", pe);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, pe);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 5))
            0:       return 32'h60000 + 32'($urandom_range(0, 2)) * 4;
            1:       return ($urandom_range(0, 1) != 0) ? LIMIT : LIMIT - 32'd4;
            default: return 32'h100 + 32'($urandom_range(0, 15)) * 4;
        endcase
    endfunction

    // Reference model: each grant fixes issue/ack times arithmetically from the access type.
    initial begin
        txn_t t;
        bit   granted, win;
        int   d, free_edge, starve, cam_end;
        free_edge = 0; starve = 0; cam_end = -1;
        forever begin
            @(posedge clk);
            pe++;
            if (rst) begin
                exp_q.delete();
                free_edge = 0; starve = 0; cam_end = -1;
            end else begin
                granted = 0; win = 0;
                if (pe >= free_edge && (cpu_req || cam_req)) begin
                    granted = 1;
                    win     = cam_req && (!cpu_req || starve == MAX_WAIT);
                    t.owner = win;
                    t.we    = win ? cam_we    : cpu_we;
                    t.addr  = win ? cam_addr  : cpu_addr;
                    t.wdata = win ? cam_wdata : cpu_wdata;
                    t.oob   = 0;
`ifdef MEM_ARB_RANGE_CHECK_EN
                    t.oob   = (t.addr >= LIMIT);
`endif
                    if (t.oob) begin
                        t.rdata = 0; t.issue = -1; d = 0;
                    end else begin
                        t.issue = pe;
                        if (t.we) begin
                            ref_mem[t.addr] = t.wdata; t.rdata = 0; d = 1;
                        end else begin
                            t.rdata = ref_mem.exists(t.addr) ? ref_mem[t.addr] : init_val(t.addr);
                            d = 1 + RD_LAT;
                        end
                    end
                    t.ack     = pe + d;
                    free_edge = pe + d + 2;
                    if (win) cam_end = pe + d + 1;
                    exp_q.push_back(t);
                end
                if (granted && win) starve = 0;
                else if (cam_req && pe > cam_end && starve < MAX_WAIT) starve++;
            end
        end
    end

    // Memory responder: data is valid only during the cycle RD_LAT after the strobe.
    initial begin
        rd_t r;
        forever begin
            @(negedge clk);
            if (rst) rd_q.delete();
            else if (mem_en) begin
                if (mem_we) phys_mem[mem_addr] = mem_wdata;
                else begin
                    r.due = pe + RD_LAT;
                    r.val = phys_mem.exists(mem_addr) ? phys_mem[mem_addr] : init_val(mem_addr);
                    rd_q.push_back(r);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rd_q.size() != 0 && rd_q[0].due == pe) mem_rdata = rd_q.pop_front().val;
            else mem_rdata = $urandom;
        end
    end

    // Monitor: compares DUT outputs every cycle against the model's queued transaction.
    initial begin
        txn_t        e;
        logic [31:0] last_cpu_rd, last_cam_rd;
        bit          exp_owner;
        last_cpu_rd = 0; last_cam_rd = 0; exp_owner = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("reset_outputs", 64'({mem_en, mem_we, cpu_ack, cam_ack, owner, busy, err,
                      |mem_addr, |mem_wdata, |cpu_rdata, |cam_rdata}), 64'd0);
                last_cpu_rd = 0; last_cam_rd = 0; exp_owner = 0;
            end else begin
                if (exp_q.size() != 0 && exp_q[0].ack < pe) begin
                    check("ack_missing", 64'(pe), 64'(exp_q[0].ack));
                    void'(exp_q.pop_front());
                end
                if (exp_q.size() != 0) exp_owner = exp_q[0].owner;
                check("busy", 64'(busy), 64'(exp_q.size() != 0));
                check("owner", 64'(owner), 64'(exp_owner));
                if (mem_en) begin
                    if (exp_q.size() == 0 || exp_q[0].issue != pe) begin
                        check("issue_cycle", 64'(pe), (exp_q.size() != 0) ? 64'(exp_q[0].issue) : 64'hFFFF_FFFF);
                    end else begin
                        e = exp_q[0];
                        check("issue_ctl", 64'({owner, mem_we}), 64'({e.owner, e.we}));
                        check("issue_addr", 64'(mem_addr), 64'(e.addr));
                        check("issue_wdata", 64'(mem_wdata), 64'(e.wdata));
                    end
                end else begin
                    check("idle_bus", 64'({mem_we, mem_addr | mem_wdata}), 64'd0);
                end
                if (cpu_ack || cam_ack) begin
                    if (exp_q.size() == 0 || exp_q[0].ack != pe) begin
                        check("ack_cycle", 64'(pe), (exp_q.size() != 0) ? 64'(exp_q[0].ack) : 64'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("ack_pair", 64'({cam_ack, cpu_ack}), e.owner ? 64'd2 : 64'd1);
                        check("ack_err", 64'(err), 64'(e.oob));
                        if (e.oob || !e.we) begin
                            if (e.owner) last_cam_rd = e.rdata;
                            else         last_cpu_rd = e.rdata;
                        end
                    end
                end else begin
                    check("err_idle", 64'(err), 64'd0);
                end
                check("cpu_rdata", 64'(cpu_rdata), 64'(last_cpu_rd));
                check("cam_rdata", 64'(cam_rdata), 64'(last_cam_rd));
            end
        end
    end

    task automatic release_req(input bit who);
        if (who) cam_req = 1'b0;
        else     cpu_req = 1'b0;
    endtask

    task automatic xfer(input bit who, input logic we, input logic [31:0] a, input logic [31:0] d);
        int t;
        if (who) begin cam_we = we; cam_addr = a; cam_wdata = d; cam_req = 1'b1; end
        else     begin cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1; end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(who ? cam_ack : cpu_ack) && t < 200);
        if (t >= 200) check("ack_timeout", 64'(who ? cam_ack : cpu_ack), 64'd1);
    endtask

    task automatic drive(input bit who, input int n, input int max_gap, input bit wr_only);
        int gap;
        for (int i = 0; i < n; i++) begin
            xfer(who, wr_only ? 1'b1 : 1'($urandom_range(0, 1)), pick_addr(), $urandom);
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            if (gap > 0 || i == n - 1) begin
                release_req(who);
                repeat (gap) @(negedge clk);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        cam_req = 0; cam_we = 0; cam_addr = 0; cam_wdata = 0;
        mem_rdata = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Lone CPU write then read-back of the same word.
        xfer(0, 1'b1, 32'h100, 32'hDEADBEEF);
        cpu_req = 0;
        repeat (2) @(negedge clk);
        xfer(0, 1'b0, 32'h100, 32'h0);
        cpu_req = 0;
        repeat (3) @(negedge clk);

        // Random mixed traffic from both requesters.
        fork
            drive(0, 40, 3, 0);
            drive(1, 40, 3, 0);
        join
        repeat (5) @(negedge clk);

        // CPU saturates the bus with back-to-back writes while the camera keeps requesting.
        fork
            drive(0, 16, 0, 1);
            drive(1, 4, 0, 1);
        join
        repeat (5) @(negedge clk);

        // Asynchronous reset landing in the WAIT phase of a CPU read.
        cpu_we = 0; cpu_addr = 32'h104; cpu_wdata = 32'h0; cpu_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        cpu_req = 1'b0;
        #1;
        check("reset_async", 64'({mem_en, cpu_ack, cam_ack, busy, owner, err, |mem_addr, |cpu_rdata}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        xfer(1, 1'b1, 32'h60004, 32'hCAFEF00D);
        cam_req = 0;
        repeat (3) @(negedge clk);

        // Both requests rise on the same cycle.
        fork
            begin xfer(0, 1'b1, 32'h108, 32'h11111111); cpu_req = 0; end
            begin xfer(1, 1'b1, 32'h10C, 32'h22222222); cam_req = 0; end
        join
        repeat (3) @(negedge clk);

        // Continuous camera pressure against random CPU traffic.
        fork
            drive(0, 20, 2, 0);
            drive(1, 20, 0, 0);
        join
        repeat (10) @(negedge clk);

        check("drain", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port data memory, including the I/O words at 0x60000/0x60004/0x60008, between two requesters: the CPU data port and the camera write/DMA port.
- Arbitrates between the two and sequences each access as issue, optional read wait, then acknowledge.
- Sits between both requesters and the memory/region-decode logic. The memory sees one master at a time.

Parameters:
- DATA_W, 32, data width of all data paths.
- ADDR_W, 32, address width.
- RD_LAT, 1, memory read latency in cycles (legal range 1..4). mem_rdata is valid RD_LAT cycles after the mem_en cycle.
- MAX_WAIT, 8, number of denied camera cycles after which the camera beats the CPU.
- LIMIT, 'h80000, first unmapped address. Used only by the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset.
- cpu_req  in  1  CPU request. Held with its signals stable until cpu_ack.
- cpu_we  in  1  CPU write enable (1 = write, 0 = read).
- cpu_addr  in  ADDR_W  CPU byte address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse to the CPU.
- cpu_rdata  out  DATA_W  CPU read data. Valid at cpu_ack, held until the next CPU read completes.
- cam_req, cam_we, cam_addr, cam_wdata, cam_ack, cam_rdata: same as the cpu_* ports, for the camera.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- owner  out  1  current/last grant (0 = CPU, 1 = camera).
- busy  out  1  high in any state other than IDLE.
- err  out  1  out-of-range flag (optional feature).

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high, port name reset.
- Outputs during reset: all 0, FSM in IDLE, starvation counter 0.
- Reset mid-operation: the in-flight transaction is dropped. No ack is issued and no mem_en is produced afterwards.
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE:
  - On an edge with any request, latch the winner's we/addr/wdata, set owner, go to ISSUE.
  - No request: stay in IDLE.
- Arbitration:
  - The CPU wins by default.
  - The camera wins if only cam_req is high, or if both are high and the starvation counter equals MAX_WAIT.
- Starvation counter:
  - Increments, saturating at MAX_WAIT, on every cycle cam_req=1 and the camera is not the active owner.
  - Clears when the camera is granted.
- ISSUE (one cycle): mem_en=1, mem_we=latched we, mem_addr/mem_wdata driven from the latch.
  - Write: go to DONE.
  - Read: go to WAIT.
- WAIT (RD_LAT cycles): mem_en=0. On the last WAIT cycle, capture mem_rdata into the owner's rdata register, then go to DONE.
- DONE (one cycle): owner's ack=1, then go to IDLE.
- Requester protocol: the requester sees ack on the edge closing DONE. It may present a new request or keep req high for a new transaction; the arbiter re-samples in IDLE.
- Latency, counted from the first IDLE sampling edge:
  - Write: ISSUE in cycle 1, ack in cycle 2.
  - Read: ack in cycle 2+RD_LAT.
- Throughput: the minimum turnaround is one IDLE cycle between transactions.
- Idle outputs: mem_we, mem_addr and mem_wdata are 0 when mem_en=0.
- Non-owner signals: the non-owner's req/addr changes during a transaction are ignored.
- A req deasserted before ack is a protocol violation. The transaction completes anyway.

Optional Feature:
- Macro: MEM_ARB_RANGE_CHECK_EN.
- With the macro defined:
  - In IDLE, a granted address >= LIMIT skips ISSUE/WAIT: no mem_en and no memory write.
  - FSM goes straight to DONE, with ack=1 and err=1 for that one cycle.
  - That port's rdata is set to 0.
  - Starvation/owner updates are unchanged.
- Without the macro: addresses pass through unchecked and err is tied to 0.

Test Plan:
- CPU write alone, cpu_addr=0x100, wdata=0xDEADBEEF: cycle 1 mem_en=mem_we=1 with addr 0x100, data 0xDEADBEEF; cycle 2 cpu_ack=1; cam_ack stays 0.
- CPU read, RD_LAT=1, memory returns 0x12345678 in cycle 2: cpu_ack in cycle 3 with cpu_rdata=0x12345678, held after ack.
- cpu_req and cam_req rise together, both writes: CPU issued first (owner=0), cpu_ack cycle 2; camera issued cycle 4, cam_ack cycle 5.
- CPU issues back-to-back writes continuously while cam_req is held, MAX_WAIT=8: the camera is granted once its counter reaches 8, then the CPU resumes; no transaction is lost.
- Reset pulsed during WAIT of a CPU read: all outputs 0 immediately, no cpu_ack; after release, a new camera write completes normally in 2 cycles.
- MEM_ARB_RANGE_CHECK_EN, CPU read at 0x80000: no mem_en, cpu_ack=err=1 in cycle 1, cpu_rdata=0. Address 0x7FFFC proceeds as a normal read.
